// File: rtl/alu_stream.sv
// Streaming ALU with valid/ready handshakes, an iterative restoring divider and status flags.
// Optional feature: define ALU_ROTATE_EN to make function 1111 rotate A left by one bit.
module alu_stream #(
    parameter int WIDTH = 8,
    parameter int FUN_W = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [FUN_W-1:0]       ALU_FUN,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [2*WIDTH-1:0]     ALU_OUT,
    output logic                   ZF,
    output logic                   CF,
    output logic                   DZ
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Single-cycle ops complete on their accept edge, so only the divider needs a busy state.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } state_t;

    function automatic logic [2*WIDTH-1:0] zext(input logic [WIDTH-1:0] v);
        return {{WIDTH{1'b0}}, v};
    endfunction

    state_t               state_r;
    state_t               state_s;
    logic                 alive_r;
    logic                 out_valid_r;
    logic [2*WIDTH-1:0]   alu_out_r;
    logic                 zf_r;
    logic                 cf_r;
    logic                 dz_r;
    logic [WIDTH-1:0]     rem_r;
    logic [WIDTH-1:0]     quo_r;
    logic [WIDTH-1:0]     dvs_r;
    logic [CNT_W-1:0]     cnt_r;

    logic                 accept_s;
    logic [3:0]           fun_lo_s;
    logic                 fun_hi_zero_s;
    logic                 div_start_s;
    logic                 div_done_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       diff_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [2*WIDTH-1:0]   op_res_s;
    logic                 op_cf_s;
    logic                 op_dz_s;
    logic [WIDTH:0]       rem_sh_s;
    logic [WIDTH:0]       trial_s;
    logic                 q_bit_s;
    logic [WIDTH-1:0]     rem_nx_s;
    logic [WIDTH-1:0]     quo_nx_s;
    logic                 load_s;
    logic [2*WIDTH-1:0]   load_res_s;
    logic                 load_cf_s;
    logic                 load_dz_s;

    assign accept_s      = IN_VALID & IN_READY;
    assign fun_lo_s      = ALU_FUN[3:0];
    assign fun_hi_zero_s = ((ALU_FUN >> 3'd4) == {FUN_W{1'b0}});
    assign div_start_s   = accept_s & fun_hi_zero_s & (fun_lo_s == 4'b0011) & (B != {WIDTH{1'b0}});
    assign div_done_s    = (state_r == ST_DIV) & (cnt_r == CNT_ZERO);

    assign sum_s  = {1'b0, A} + {1'b0, B};
    assign diff_s = {1'b0, A} - {1'b0, B};
    assign prod_s = zext(A) * zext(B);

    // Restoring step: the top bit of the trial subtraction is the borrow, i.e. the inverted quotient bit.
    assign rem_sh_s = {rem_r, quo_r[WIDTH-1]};
    assign trial_s  = rem_sh_s - {1'b0, dvs_r};
    assign q_bit_s  = ~trial_s[WIDTH];
    assign rem_nx_s = q_bit_s ? trial_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
    assign quo_nx_s = {quo_r[WIDTH-2:0], q_bit_s};

    assign IN_READY  = alive_r & (state_r == ST_IDLE) & (~out_valid_r | OUT_READY);
    assign OUT_VALID = out_valid_r;
    assign ALU_OUT   = alu_out_r;
    assign ZF        = zf_r;
    assign CF        = cf_r;
    assign DZ        = dz_r;

    // Result and flags of the single-cycle operations (including divide-by-zero).
    always_comb begin
        op_res_s = {2*WIDTH{1'b0}};
        op_cf_s  = 1'b0;
        op_dz_s  = 1'b0;
        if (fun_hi_zero_s) begin
            case (fun_lo_s)
                4'b0000: begin
                    op_res_s = zext(sum_s[WIDTH-1:0]);
                    op_cf_s  = sum_s[WIDTH];
                end
                4'b0001: begin
                    op_res_s = zext(diff_s[WIDTH-1:0]);
                    op_cf_s  = diff_s[WIDTH];
                end
                4'b0010: op_res_s = prod_s;
                4'b0011: begin
                    if (B == {WIDTH{1'b0}}) begin
                        op_res_s = {A, {WIDTH{1'b1}}};
                        op_dz_s  = 1'b1;
                    end else begin
                        op_res_s = {2*WIDTH{1'b0}};
                    end
                end
                4'b0100: op_res_s = zext(A & B);
                4'b0101: op_res_s = zext(A | B);
                4'b0110: op_res_s = zext(~(A & B));
                4'b0111: op_res_s = zext(~(A | B));
                4'b1000: op_res_s = zext(A ^ B);
                4'b1001: op_res_s = zext(~(A ^ B));
                4'b1010: op_res_s = (A == B) ? {{(2*WIDTH-2){1'b0}}, 2'd1} : {2*WIDTH{1'b0}};
                4'b1011: op_res_s = (A > B)  ? {{(2*WIDTH-2){1'b0}}, 2'd2} : {2*WIDTH{1'b0}};
                4'b1100: op_res_s = (A < B)  ? {{(2*WIDTH-2){1'b0}}, 2'd3} : {2*WIDTH{1'b0}};
                4'b1101: op_res_s = zext({1'b0, A[WIDTH-1:1]});
                4'b1110: op_res_s = {{(WIDTH-1){1'b0}}, A, 1'b0};
`ifdef ALU_ROTATE_EN
                4'b1111: op_res_s = zext({A[WIDTH-2:0], A[WIDTH-1]});
`else
                4'b1111: op_res_s = {2*WIDTH{1'b0}};
`endif
                default: op_res_s = {2*WIDTH{1'b0}};
            endcase
        end else begin
            op_res_s = {2*WIDTH{1'b0}};
        end
    end

    // Select what gets loaded into the output register: divider completion or a single-cycle op.
    always_comb begin
        load_s     = (accept_s & ~div_start_s) | div_done_s;
        load_res_s = op_res_s;
        load_cf_s  = op_cf_s;
        load_dz_s  = op_dz_s;
        if (div_done_s) begin
            load_res_s = {rem_nx_s, quo_nx_s};
            load_cf_s  = 1'b0;
            load_dz_s  = 1'b0;
        end else begin
            load_res_s = op_res_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (div_start_s) begin
                    state_s = ST_DIV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DIV;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register; alive_r keeps IN_READY low while reset is asserted.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
            alive_r <= 1'b0;
        end else begin
            state_r <= state_s;
            alive_r <= 1'b1;
        end
    end

    // Divider datapath: load operands on accept, then one quotient bit per cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rem_r <= {WIDTH{1'b0}};
            quo_r <= {WIDTH{1'b0}};
            dvs_r <= {WIDTH{1'b0}};
            cnt_r <= CNT_ZERO;
        end else if (div_start_s) begin
            rem_r <= {WIDTH{1'b0}};
            quo_r <= A;
            dvs_r <= B;
            cnt_r <= CNT_LAST;
        end else if (state_r == ST_DIV) begin
            rem_r <= rem_nx_s;
            quo_r <= quo_nx_s;
            if (cnt_r != CNT_ZERO) begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end
    end

    // Output register: loading wins over draining so back-to-back results keep OUT_VALID high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid_r <= 1'b0;
            alu_out_r   <= {2*WIDTH{1'b0}};
            zf_r        <= 1'b0;
            cf_r        <= 1'b0;
            dz_r        <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            alu_out_r   <= load_res_s;
            zf_r        <= (load_res_s == {2*WIDTH{1'b0}});
            cf_r        <= load_cf_s;
            dz_r        <= load_dz_s;
        end else if (out_valid_r & OUT_READY) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_stream.sv
// Directed and randomized bench for alu_stream (WIDTH=8) against an arithmetic reference model.
module tb_alu_stream;

    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [3:0]  ALU_FUN;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] ALU_OUT;
    logic        ZF;
    logic        CF;
    logic        DZ;

    int vectors    = 0;
    int miscompares = 0;

    alu_stream #(.WIDTH(8), .FUN_W(4)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .ALU_FUN(ALU_FUN), .A(A), .B(B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .ALU_OUT(ALU_OUT), .ZF(ZF), .CF(CF), .DZ(DZ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the function code.
    task automatic model(input int fun, input int a, input int b,
                         output int res, output int cf, output int dz, output int lat);
        res = 0; cf = 0; dz = 0; lat = 1;
        case (fun)
            0:  begin res = (a + b) % 256; cf = (a + b > 255) ? 1 : 0; end
            1:  begin res = (a - b + 256) % 256; cf = (a < b) ? 1 : 0; end
            2:  res = a * b;
            3:  begin
                    if (b == 0) begin res = a * 256 + 255; dz = 1; end
                    else begin res = (a % b) * 256 + a / b; lat = 9; end
                end
            4:  res = a & b;
            5:  res = a | b;
            6:  res = 255 - (a & b);
            7:  res = 255 - (a | b);
            8:  res = a ^ b;
            9:  res = 255 - (a ^ b);
            10: res = (a == b) ? 1 : 0;
            11: res = (a > b) ? 2 : 0;
            12: res = (a < b) ? 3 : 0;
            13: res = a / 2;
            14: res = a * 2;
`ifdef ALU_ROTATE_EN
            15: res = (a * 2) % 256 + a / 128;
`else
            15: res = 0;
`endif
            default: res = 0;
        endcase
    endtask

    // One complete transaction: accept, wait with a bound, check, hold for `stall` cycles, drain.
    task automatic run_op(input int fun, input int a, input int b, input int stall);
        int res, cf, dz, lat, n;
        model(fun, a, b, res, cf, dz, lat);
        ALU_FUN = fun[3:0]; A = a[7:0]; B = b[7:0]; IN_VALID = 1'b1; OUT_READY = 1'b0;
        #1;
        check("accept_ready", IN_READY, 1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0; A = 8'($urandom); B = 8'($urandom); ALU_FUN = 4'($urandom);
        n = 1;
        while (!OUT_VALID && n < 40) begin
            check("busy_ready", IN_READY, 0);
            @(posedge CLK); #1;
            n++;
        end
        check("latency", n, lat);
        check("result", ALU_OUT, res);
        check("zf", ZF, (res == 0) ? 1 : 0);
        check("cf", CF, cf);
        check("dz", DZ, dz);
        for (int i = 0; i < stall; i++) begin
            @(posedge CLK); #1;
            check("hold_valid", OUT_VALID, 1);
            check("hold_result", ALU_OUT, res);
            check("hold_ready", IN_READY, 0);
        end
        OUT_READY = 1'b1;
        #1;
        check("drain_ready", IN_READY, 1);
        @(posedge CLK); #1;
        check("drained", OUT_VALID, 0);
        OUT_READY = 1'b0;
    endtask

    initial begin
        int n, a, b, fun, r;
        RST = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; ALU_FUN = 4'd0; A = 8'd0; B = 8'd0;
        #3;
        check("rst_in_ready", IN_READY, 0);
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_alu_out", ALU_OUT, 0);
        check("rst_flags", {ZF, CF, DZ}, 0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1;
        check("post_rst_ready", IN_READY, 1);

        // Directed cases from the test plan.
        run_op(0, 8'hFF, 8'h01, 0);
        run_op(3, 8'hC8, 8'h07, 1);
        run_op(3, 8'h55, 8'h00, 0);
        run_op(15, 8'h81, 8'h00, 0);
        run_op(1, 8'h10, 8'h20, 0);

        // Back-pressure followed by a same-cycle drain and accept.
        ALU_FUN = 4'b0010; A = 8'h10; B = 8'h10; IN_VALID = 1'b1; OUT_READY = 1'b0;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        check("bp_valid", OUT_VALID, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            check("bp_hold", ALU_OUT, 16'h0100);
            check("bp_ready", IN_READY, 0);
        end
        ALU_FUN = 4'b0100; A = 8'hF0; B = 8'h3C; IN_VALID = 1'b1; OUT_READY = 1'b1;
        #1;
        check("bp_same_cycle_ready", IN_READY, 1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        check("bp_next_valid", OUT_VALID, 1);
        check("bp_next_result", ALU_OUT, 16'h0030);
        @(posedge CLK); #1;
        check("bp_drained", OUT_VALID, 0);
        OUT_READY = 1'b0;

        // Reset in the middle of a divide discards everything.
        ALU_FUN = 4'b0011; A = 8'hC8; B = 8'h07; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        check("mid_rst_valid", OUT_VALID, 0);
        check("mid_rst_out", ALU_OUT, 0);
        check("mid_rst_ready", IN_READY, 0);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1;
        check("mid_rst_release_ready", IN_READY, 1);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (OUT_VALID) n++;
        end
        check("no_stale_result", n, 0);

        // Randomized operations with random back-pressure.
        for (int k = 0; k < 150; k++) begin
            fun = $urandom_range(0, 15);
            a   = $urandom_range(0, 255);
            r   = $urandom_range(0, 9);
            if (r == 0)      b = 0;
            else if (r == 1) b = a;
            else             b = $urandom_range(0, 255);
            run_op(fun, a, b, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
